// File: rtl/profile_counter_ctrl.sv
// ---------------------------------------------------------------------------
// profile_counter_ctrl
//
// Drives an external profiling up/down counter (reset, enable, direction)
// from start/stop event pulses, then reads the counter back once it has
// settled and offers the elapsed count on a valid/ack handshake.
//
// Ports:
//   clock            - single clock, rising-edge active
//   reset            - asynchronous, active-low
//   start            - pulse, begins a measurement (honoured in IDLE only)
//   stop             - pulse, ends a measurement (honoured in RUN only)
//   abort            - level, abandons any measurement
//   counterValue     - current counter value (registered in the counter)
//   counterReset     - registered synchronous clear to the counter
//   counterEnable    - registered count enable to the counter
//   counterDirection - constant 1 (count up)
//   resultValid      - registered, result available
//   resultData       - registered elapsed count, saturated on overflow
//   resultAck        - consumer acceptance of the result
//   overflow         - sticky, counter wrapped during current/last measurement
//   busy             - high whenever a measurement is in progress or pending
// ---------------------------------------------------------------------------
module profile_counter_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             abort,
   input  logic [WIDTH-1:0] counterValue,
   output logic             counterReset,
   output logic             counterEnable,
   output logic             counterDirection,
   output logic             resultValid,
   output logic [WIDTH-1:0] resultData,
   input  logic             resultAck,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic             cnt_reset_reg, cnt_reset_next;
   logic             cnt_enable_reg, cnt_enable_next;
   logic             valid_reg, valid_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic             overflow_reg, overflow_next;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         cnt_reset_reg  <= 1'b0;
         cnt_enable_reg <= 1'b0;
         valid_reg      <= 1'b0;
         data_reg       <= '0;
         overflow_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reset_reg  <= cnt_reset_next;
         cnt_enable_reg <= cnt_enable_next;
         valid_reg      <= valid_next;
         data_reg       <= data_next;
         overflow_reg   <= overflow_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_reset_next  = cnt_reset_reg;
      cnt_enable_next = cnt_enable_reg;
      valid_next      = valid_reg;
      data_next       = data_reg;
      overflow_next   = overflow_reg;

      case (state_reg)
         IDLE: begin
            // start has priority over a coincident stop, which is ignored here
            if (start) begin
               state_next     = CLEAR;
               cnt_reset_next = 1'b1;
               overflow_next  = 1'b0;
            end
         end
         CLEAR: begin
            state_next      = RUN;
            cnt_reset_next  = 1'b0;
            cnt_enable_next = 1'b1;
         end
         RUN: begin
            // The counter sits at all ones and is about to wrap on this edge.
            if (cnt_enable_reg && (counterValue == {WIDTH{1'b1}}))
               overflow_next = 1'b1;
            if (stop) begin
               state_next      = CAPTURE;
               cnt_enable_next = 1'b0;
            end
         end
         CAPTURE: begin
            // One idle cycle so the counter's last increment is visible.
            state_next = HOLD;
            data_next  = overflow_reg ? {WIDTH{1'b1}} : counterValue;
            valid_next = 1'b1;
         end
         HOLD: begin
            if (resultAck) begin
               state_next = IDLE;
               valid_next = 1'b0;
            end
         end
         default: begin
            state_next      = IDLE;
            cnt_reset_next  = 1'b0;
            cnt_enable_next = 1'b0;
            valid_next      = 1'b0;
         end
      endcase

      // abort overrides every state but keeps overflow and the last result
      if (abort) begin
         state_next      = IDLE;
         cnt_reset_next  = 1'b0;
         cnt_enable_next = 1'b0;
         valid_next      = 1'b0;
      end
   end

   assign counterReset     = cnt_reset_reg;
   assign counterEnable    = cnt_enable_reg;
   assign counterDirection = 1'b1;
   assign resultValid      = valid_reg;
   assign resultData       = data_reg;
   assign overflow         = overflow_reg;
   assign busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_profile_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_profile_counter_ctrl
//
// Two instances (WIDTH=4 and WIDTH=32) share one stimulus stream, each with
// its own simple up-counter. A timestamp-based reference model predicts all
// outputs from the start/stop edge numbers; one negedge process compares both
// instances against it every cycle. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_profile_counter_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0, stop = 1'b0, abort = 1'b0, resultAck = 1'b0;

   logic [3:0]  cv4 = '0;
   logic [31:0] cv32 = '0;
   logic cr4, ce4, cd4, rv4, ov4, bz4;
   logic cr32, ce32, cd32, rv32, ov32, bz32;
   logic [3:0]  rd4;
   logic [31:0] rd32;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   always #5 clock = ~clock;

   profile_counter_ctrl #(.WIDTH(4)) dut4 (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .abort(abort),
      .counterValue(cv4), .counterReset(cr4), .counterEnable(ce4),
      .counterDirection(cd4), .resultValid(rv4), .resultData(rd4),
      .resultAck(resultAck), .overflow(ov4), .busy(bz4));

   profile_counter_ctrl #(.WIDTH(32)) dut32 (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .abort(abort),
      .counterValue(cv32), .counterReset(cr32), .counterEnable(ce32),
      .counterDirection(cd32), .resultValid(rv32), .resultData(rd32),
      .resultAck(resultAck), .overflow(ov32), .busy(bz32));

   // External counters (not touched by the controller's async reset).
   always @(posedge clock) begin
      if (cr4) cv4 <= '0; else if (ce4) cv4 <= cd4 ? cv4 + 4'd1 : cv4 - 4'd1;
      if (cr32) cv32 <= '0; else if (ce32) cv32 <= cd32 ? cv32 + 32'd1 : cv32 - 32'd1;
   end

   // Reference model: edge numbers of the accepted start (m_t) and stop (m_s).
   // Increments happen on edges t+2..s, so n = s-t-1; overflow once the count
   // of increments reaches 2**WIDTH; result saturates in that case.
   longint cyc = 0, m_t = 0, m_s = -1, n;
   bit     m_active = 0, m_valid = 0, m_ovf4 = 0, m_ovf32 = 0;
   longint m_data4 = 0, m_data32 = 0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_active = 0; m_valid = 0; m_s = -1;
         m_ovf4 = 0; m_ovf32 = 0; m_data4 = 0; m_data32 = 0;
      end else begin
         cyc = cyc + 1;
         if (abort) begin
            m_active = 0; m_valid = 0; m_s = -1;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1; m_t = cyc; m_s = -1; m_ovf4 = 0; m_ovf32 = 0;
            end
         end else if (m_valid) begin
            if (resultAck) begin m_active = 0; m_valid = 0; end
         end else if (m_s < 0) begin
            if (cyc >= m_t + 2) begin
               n = cyc - m_t - 1;
               if (n >= 16) m_ovf4 = 1;
               if (n >= 64'h1_0000_0000) m_ovf32 = 1;
               if (stop) m_s = cyc;
            end
         end else begin
            n = m_s - m_t - 1;
            m_valid  = 1;
            m_data4  = (n >= 16) ? 15 : n;
            m_data32 = (n >= 64'h1_0000_0000) ? 64'hFFFF_FFFF : n;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (checking && reset) begin
         logic exp_cr, exp_ce;
         exp_cr = m_active && (cyc == m_t);
         exp_ce = m_active && !m_valid && (m_s < 0) && (cyc > m_t);
         chk("cr4", {63'd0, cr4}, {63'd0, exp_cr});
         chk("ce4", {63'd0, ce4}, {63'd0, exp_ce});
         chk("dir4", {63'd0, cd4}, 64'd1);
         chk("rv4", {63'd0, rv4}, {63'd0, m_valid});
         chk("rd4", {60'd0, rd4}, m_data4);
         chk("ov4", {63'd0, ov4}, {63'd0, m_ovf4});
         chk("bz4", {63'd0, bz4}, {63'd0, m_active});
         chk("cr32", {63'd0, cr32}, {63'd0, exp_cr});
         chk("ce32", {63'd0, ce32}, {63'd0, exp_ce});
         chk("dir32", {63'd0, cd32}, 64'd1);
         chk("rv32", {63'd0, rv32}, {63'd0, m_valid});
         chk("rd32", {32'd0, rd32}, m_data32);
         chk("ov32", {63'd0, ov32}, {63'd0, m_ovf32});
         chk("bz32", {63'd0, bz32}, {63'd0, m_active});
      end
   end

   // Inputs set 2ns after an edge are sampled at the following edge.
   task automatic step(input logic st, input logic sp, input logic ab, input logic ak);
      @(posedge clock); #2;
      start = st; stop = sp; abort = ab; resultAck = ak;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 0);
   endtask

   // start accepted at edge t, stop at edge t+k, then wait until result is up.
   task automatic measure(input int k);
      step(1, 0, 0, 0);
      idle(k - 1);
      step(0, 1, 0, 0);
      idle(2);
   endtask

   task automatic ack();
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
   endtask

   initial begin
      #1 reset = 1'b0;
      idle(3);
      chk("rst_rv4", {63'd0, rv4}, 64'd0);
      chk("rst_rd32", {32'd0, rd32}, 64'd0);
      chk("rst_bz32", {63'd0, bz32}, 64'd0);
      chk("rst_dir32", {63'd0, cd32}, 64'd1);
      reset = 1'b1;
      checking = 1'b1;
      idle(2);

      // Basic measurement: stop at t+11 -> 10
      measure(11);
      chk("basic_rv32", {63'd0, rv32}, 64'd1);
      chk("basic_rd32", {32'd0, rd32}, 64'd10);
      chk("basic_ov32", {63'd0, ov32}, 64'd0);
      $display("txn basic: rd32=%0d rd4=%0d ov4=%0b", rd32, rd4, ov4);
      ack();
      chk("basic_ack_rv", {63'd0, rv32}, 64'd0);
      chk("basic_ack_bz", {63'd0, bz32}, 64'd0);

      // Overflow: 19 increments saturate the 4-bit instance only
      measure(20);
      chk("ovf_ov4", {63'd0, ov4}, 64'd1);
      chk("ovf_rd4", {60'd0, rd4}, 64'hF);
      chk("ovf_rd32", {32'd0, rd32}, 64'd19);
      chk("ovf_ov32", {63'd0, ov32}, 64'd0);
      $display("txn overflow: rd32=%0d rd4=%0h ov4=%0b", rd32, rd4, ov4);
      ack();
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("ovf_clear", {63'd0, ov4}, 64'd0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Handshake hold: 50 cycles without ack, start pulses ignored
      measure(4);
      for (int i = 0; i < 50; i++) step((i % 5) == 0, 0, 0, 0);
      chk("hold_rv4", {63'd0, rv4}, 64'd1);
      chk("hold_rd4", {60'd0, rd4}, 64'd3);
      chk("hold_bz4", {63'd0, bz4}, 64'd1);
      $display("txn hold: rd4=%0d rv4=%0b", rd4, rv4);
      step(1, 0, 0, 1);  // start with ack is ignored
      step(0, 0, 0, 0);
      chk("hold_ack_bz", {63'd0, bz4}, 64'd0);
      idle(2);
      chk("hold_no_restart", {63'd0, bz4}, 64'd0);

      // start+stop together, stop in CLEAR lost, stop at t+6 -> 5
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      idle(4);
      step(0, 1, 0, 0);
      idle(2);
      chk("simul_rd4", {60'd0, rd4}, 64'd5);
      chk("simul_rd32", {32'd0, rd32}, 64'd5);
      $display("txn simul: rd32=%0d", rd32);
      ack();

      // Abort during RUN
      step(1, 0, 0, 0);
      idle(5);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("abort_ce", {63'd0, ce32}, 64'd0);
      chk("abort_bz", {63'd0, bz32}, 64'd0);
      idle(3);
      chk("abort_rv", {63'd0, rv32}, 64'd0);
      chk("abort_rd", {32'd0, rd32}, 64'd5);
      $display("txn abort: rd32=%0d busy=%0b", rd32, bz32);

      // Async reset mid-RUN after a 4-bit wrap
      step(1, 0, 0, 0);
      idle(20);
      chk("arst_pre_ov4", {63'd0, ov4}, 64'd1);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      chk("arst_ce4", {63'd0, ce4}, 64'd0);
      chk("arst_ov4", {63'd0, ov4}, 64'd0);
      chk("arst_rv4", {63'd0, rv4}, 64'd0);
      chk("arst_bz4", {63'd0, bz4}, 64'd0);
      #2 reset = 1'b1;
      idle(1);
      measure(3);
      chk("arst_after_rd32", {32'd0, rd32}, 64'd2);
      $display("txn async_reset: rd32=%0d", rd32);
      ack();
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
